// File: rtl/add_sub_checker.sv
// Response checker for a WIDTH-bit adder/subtractor: queues golden results for
// the operand stream, compares them in order against DUT results, and reports a verdict.
module add_sub_checker #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic                 res_valid,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [4*WIDTH+2:0]   fail_info,
    output logic                 err_underflow,
    output logic                 err_overflow,
    output logic                 err_timeout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass
);

    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW     = AW + 1;
    localparam int unsigned OPW    = 2 * WIDTH + 1;
    localparam int unsigned RW     = WIDTH + 1;
    localparam int unsigned INFO_W = 4 * WIDTH + 3;
    localparam int unsigned TW     = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [OPW-1:0]      mem_q [DEPTH];
    logic [OPW-1:0]      mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]       occ_q, occ_d;
    logic [TW-1:0]       drain_q, drain_d;
    logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic [INFO_W-1:0]   fail_info_q, fail_info_d;
    logic                err_underflow_q, err_underflow_d;
    logic                err_overflow_q, err_overflow_d;
    logic                err_timeout_q, err_timeout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [OPW-1:0]      op_in;
    logic [OPW-1:0]      cmp_op;
    logic [RW-1:0]       exp_res;
    logic                in_run, in_active, fifo_empty, fifo_full;
    logic                bypass, pop, push, underflow, overflow, cmp_valid, mismatch;

    // Golden {cout,sum}; subtract is a + ~b + 1 so cout means "no borrow".
    function automatic logic [RW-1:0] golden(input logic [OPW-1:0] op);
        logic             oc;
        logic [WIDTH-1:0] oa;
        logic [WIDTH-1:0] ob;
        {oc, oa, ob} = op;
        if (oc) begin
            golden = RW'({1'b0, oa}) + RW'({1'b0, ~ob}) + RW'(1);
        end else begin
            golden = RW'({1'b0, oa}) + RW'({1'b0, ob});
        end
    endfunction

    // Datapath decode for this cycle's push/pop/compare events.
    always_comb begin
        op_in      = {cin, a, b};
        in_run     = (state_q == ST_RUN);
        in_active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        fifo_empty = (occ_q == '0);
        fifo_full  = (occ_q == OW'(DEPTH));
        bypass     = in_run & in_valid & res_valid & fifo_empty;
        pop        = in_active & res_valid & ~fifo_empty;
        underflow  = in_active & res_valid & fifo_empty & ~bypass;
        push       = in_run & in_valid & ~bypass & (~fifo_full | pop);
        overflow   = in_run & in_valid & fifo_full & ~pop;
        cmp_valid  = pop | bypass;
        cmp_op     = bypass ? op_in : mem_q[rd_ptr_q];
        exp_res    = golden(cmp_op);
        mismatch   = ({dut_cout, dut_sum} != exp_res);
    end

    // Next-state for FSM, FIFO, counters and sticky flags; start clears everything.
    always_comb begin
        state_d         = state_q;
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occ_d           = occ_q;
        drain_d         = drain_q;
        pass_cnt_d      = pass_cnt_q;
        fail_cnt_d      = fail_cnt_q;
        fail_info_d     = fail_info_q;
        err_underflow_d = err_underflow_q;
        err_overflow_d  = err_overflow_q;
        err_timeout_d   = err_timeout_q;

        if (start) begin
            state_d         = ST_RUN;
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            occ_d           = '0;
            drain_d         = '0;
            pass_cnt_d      = '0;
            fail_cnt_d      = '0;
            fail_info_d     = '0;
            err_underflow_d = 1'b0;
            err_overflow_d  = 1'b0;
            err_timeout_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = op_in;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + OW'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - OW'(1);
            end

            // fail_info freezes on the first mismatch since start.
            if (cmp_valid) begin
                if (mismatch) begin
                    if (fail_cnt_q == '0) begin
                        fail_info_d = {cmp_op, exp_res, dut_cout, dut_sum};
                    end
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + CNT_W'(1);
                    end
                end else if (pass_cnt_q != '1) begin
                    pass_cnt_d = pass_cnt_q + CNT_W'(1);
                end
            end
            if (underflow) begin
                err_underflow_d = 1'b1;
            end
            if (overflow) begin
                err_overflow_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_d = drain_q + TW'(1);
                        if (drain_d == TW'(DRAIN_TIMEOUT)) begin
                            state_d       = ST_DONE;
                            err_timeout_d = 1'b1;
                        end
                    end
                end
                ST_DONE: ;
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Expected-value storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            drain_q         <= '0;
            pass_cnt_q      <= '0;
            fail_cnt_q      <= '0;
            fail_info_q     <= '0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_timeout_q   <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            drain_q         <= drain_d;
            pass_cnt_q      <= pass_cnt_d;
            fail_cnt_q      <= fail_cnt_d;
            fail_info_q     <= fail_info_d;
            err_underflow_q <= err_underflow_d;
            err_overflow_q  <= err_overflow_d;
            err_timeout_q   <= err_timeout_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign pass_cnt      = pass_cnt_q;
    assign fail_cnt      = fail_cnt_q;
    assign fail_info     = fail_info_q;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;
    assign err_timeout   = err_timeout_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q & (fail_cnt_q == '0) & ~err_underflow_q
                           & ~err_overflow_q & ~err_timeout_q;

endmodule

// File: tb/tb_add_sub_checker.sv
// Bench for add_sub_checker: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and randomized latency/corruption rounds.
module tb_add_sub_checker;

    localparam int unsigned WIDTH         = 4;
    localparam int unsigned DEPTH         = 8;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned DRAIN_TIMEOUT = 64;
    localparam int unsigned IW            = 4 * WIDTH + 3;
    localparam int          CNT_MAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0, stop = 1'b0, in_valid = 1'b0, cin = 1'b0;
    logic             res_valid = 1'b0, dut_cout = 1'b0;
    logic [3:0]       a = '0, b = '0, dut_sum = '0;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic [IW-1:0]    fail_info;
    logic             err_underflow, err_overflow, err_timeout, busy, done, pass;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    add_sub_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .res_valid(res_valid), .dut_sum(dut_sum),
        .dut_cout(dut_cout), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_info(fail_info), .err_underflow(err_underflow),
        .err_overflow(err_overflow), .err_timeout(err_timeout), .busy(busy),
        .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       c;
        logic [3:0] a;
        logic [3:0] b;
    } op_t;

    typedef struct {
        op_t o;
        int  rdy;
    } pend_t;

    // Reference model state: 0 idle, 1 run, 2 drain, 3 done.
    op_t           mq[$];
    int            m_state = 0;
    int            m_pass = 0, m_fail = 0, m_drain = 0;
    logic [IW-1:0] m_info = '0;
    bit            m_und = 0, m_ovf = 0, m_tmo = 0;

    function automatic logic [4:0] ref_calc(input logic c, input int x, input int y);
        if (!c) return 5'(x + y);
        return {(x >= y) ? 1'b1 : 1'b0, 4'((x - y) & 15)};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_pass = 0; m_fail = 0; m_drain = 0; m_info = '0;
        m_und = 0; m_ovf = 0; m_tmo = 0;
    endtask

    task automatic model_compare(input op_t o, input logic [3:0] ds, input logic dc);
        logic [4:0] e;
        e = ref_calc(o.c, int'(o.a), int'(o.b));
        if ({dc, ds} == e) begin
            if (m_pass < CNT_MAX) m_pass++;
        end else begin
            if (m_fail == 0) m_info = {o.c, o.a, o.b, e, dc, ds};
            if (m_fail < CNT_MAX) m_fail++;
        end
    endtask

    task automatic model_step();
        op_t inop;
        bit  was_empty, byp;
        inop = {cin, a, b};
        if (start) begin
            model_clear();
            m_state = 1;
            return;
        end
        if (m_state == 1 || m_state == 2) begin
            was_empty = (mq.size() == 0);
            byp = 0;
            if (res_valid) begin
                if (!was_empty) model_compare(mq.pop_front(), dut_sum, dut_cout);
                else if (m_state == 1 && in_valid) begin
                    byp = 1;
                    model_compare(inop, dut_sum, dut_cout);
                end else m_und = 1;
            end
            if (m_state == 1 && in_valid && !byp) begin
                if (mq.size() < DEPTH) mq.push_back(inop);
                else m_ovf = 1;
            end
            if (m_state == 1 && stop) begin
                m_state = 2;
                m_drain = 0;
            end else if (m_state == 2) begin
                if (was_empty) m_state = 3;
                else begin
                    m_drain++;
                    if (m_drain >= DRAIN_TIMEOUT) begin
                        m_state = 3;
                        m_tmo = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_clear();
                m_state = 0;
            end else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic m_busy, m_done, m_pv;
        wait (chk_en);
        forever begin
            @(negedge clk);
            m_busy = (m_state == 1 || m_state == 2);
            m_done = (m_state == 3);
            m_pv   = m_done && m_fail == 0 && !m_und && !m_ovf && !m_tmo;
            n_cmp++;
            if (pass_cnt !== CNT_W'(m_pass) || fail_cnt !== CNT_W'(m_fail) ||
                fail_info !== m_info || err_underflow !== m_und ||
                err_overflow !== m_ovf || err_timeout !== m_tmo ||
                busy !== m_busy || done !== m_done || pass !== m_pv) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got pc=%0d fc=%0d info=%h u=%b o=%b t=%b busy=%b done=%b pass=%b required pc=%0d fc=%0d info=%h u=%b o=%b t=%b busy=%b done=%b pass=%b",
                         $time, pass_cnt, fail_cnt, fail_info, err_underflow, err_overflow,
                         err_timeout, busy, done, pass, m_pass, m_fail, m_info, m_und,
                         m_ovf, m_tmo, m_busy, m_done, m_pv);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic iv,
                         input logic [3:0] ia, input logic [3:0] ib, input logic ic,
                         input logic rv, input logic [3:0] s, input logic co);
        start = st; stop = sp; in_valid = iv; a = ia; b = ib; cin = ic;
        res_valid = rv; dut_sum = s; dut_cout = co;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
    endtask

    task automatic push_op(input op_t o);
        drive(0, 0, 1, o.a, o.b, o.c, 0, 4'd0, 0);
    endtask

    task automatic bypass_op(input op_t o, input logic corrupt);
        logic [4:0] e;
        e = ref_calc(o.c, int'(o.a), int'(o.b));
        if (corrupt) e = e ^ 5'h01;
        drive(0, 0, 1, o.a, o.b, o.c, 1, e[3:0], e[4]);
    endtask

    task automatic result_for(input op_t o);
        logic [4:0] e;
        e = ref_calc(o.c, int'(o.a), int'(o.b));
        drive(0, 0, 0, 4'd0, 4'd0, 0, 1, e[3:0], e[4]);
    endtask

    function automatic op_t rand_op();
        return {1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15))};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t   vec [8];
        op_t   ov [10];
        pend_t pq[$];
        logic [4:0] e;

        vec[0] = {1'b0, 4'd5, 4'd10};
        vec[1] = {1'b1, 4'd14, 4'd9};
        vec[2] = {1'b1, 4'd3, 4'd11};
        vec[3] = {1'b1, 4'd9, 4'd4};
        vec[4] = {1'b0, 4'd4, 4'd8};
        vec[5] = {1'b1, 4'd7, 4'd7};
        vec[6] = {1'b0, 4'd15, 4'd1};
        vec[7] = {1'b1, 4'd2, 4'd6};

        // Pin the reference arithmetic with hand-computed values.
        check("ref_5p10", 32'(ref_calc(1'b0, 5, 10)), 32'h0F);
        check("ref_14m9", 32'(ref_calc(1'b1, 14, 9)), 32'h15);
        check("ref_3m11", 32'(ref_calc(1'b1, 3, 11)), 32'h08);
        check("ref_9m4", 32'(ref_calc(1'b1, 9, 4)), 32'h15);
        check("ref_4p8", 32'(ref_calc(1'b0, 4, 8)), 32'h0C);

        #2 rst = 1'b1;
        #1 chk_en = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pass_cnt", 32'(pass_cnt), 32'd0);

        // Zero-latency stream with correct answers.
        drive(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 5; i++) bypass_op(vec[i], 1'b0);
        drive(0, 1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        check("zl_draining", 32'(busy), 32'd1);
        idle(1);
        check("zl_done", 32'(done), 32'd1);
        check("zl_pass_cnt", 32'(pass_cnt), 32'd5);
        check("zl_fail_cnt", 32'(fail_cnt), 32'd0);
        check("zl_pass", 32'(pass), 32'd1);
        drive(0, 0, 0, 4'd0, 4'd0, 0, 1, 4'd3, 1);
        check("done_ignores_res", 32'({pass_cnt, err_underflow}), 32'({8'd5, 1'b0}));

        // Two-cycle-latency responder, corrupting results 2 and 6.
        drive(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        for (int c = 0; c < 10; c++) begin
            logic iv, rv;
            logic [3:0] ia, ib;
            logic ic;
            iv = (c < 8);
            ia = iv ? vec[c % 8].a : 4'd0;
            ib = iv ? vec[c % 8].b : 4'd0;
            ic = iv ? vec[c % 8].c : 1'b0;
            rv = (c >= 2);
            e = 5'd0;
            if (rv) begin
                e = ref_calc(vec[c-2].c, int'(vec[c-2].a), int'(vec[c-2].b));
                if (c - 2 == 2 || c - 2 == 6) e = e ^ 5'h01;
            end
            drive(0, 0, iv, ia, ib, ic, rv, e[3:0], e[4]);
            if (c == 4) begin
                check("lat2_first_fail_cnt", 32'(fail_cnt), 32'd1);
                check("lat2_first_info", 32'(fail_info),
                      32'({1'b1, 4'd3, 4'd11, 1'b0, 4'd8, 1'b0, 4'd9}));
            end
        end
        drive(0, 1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        idle(1);
        check("lat2_fail_cnt", 32'(fail_cnt), 32'd2);
        check("lat2_pass_cnt", 32'(pass_cnt), 32'd6);
        check("lat2_info_frozen", 32'(fail_info),
              32'({1'b1, 4'd3, 4'd11, 1'b0, 4'd8, 1'b0, 4'd9}));
        check("lat2_pass", 32'({done, pass}), 32'b10);

        // Overflow, then simultaneous push/pop on a full FIFO, then underflow.
        drive(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 10; i++) ov[i] = rand_op();
        for (int i = 0; i < 8; i++) push_op(ov[i]);
        check("full_no_ovf", 32'(err_overflow), 32'd0);
        push_op(ov[8]);
        check("ovf_set", 32'(err_overflow), 32'd1);
        e = ref_calc(ov[0].c, int'(ov[0].a), int'(ov[0].b));
        drive(0, 0, 1, ov[9].a, ov[9].b, ov[9].c, 1, e[3:0], e[4]);
        for (int i = 1; i < 8; i++) result_for(ov[i]);
        result_for(ov[9]);
        check("ovf_occupancy_pass_cnt", 32'(pass_cnt), 32'd9);
        check("ovf_no_underflow", 32'(err_underflow), 32'd0);
        drive(0, 0, 0, 4'd0, 4'd0, 0, 1, 4'd1, 0);
        check("underflow_set", 32'(err_underflow), 32'd1);
        check("underflow_counts", 32'({pass_cnt, fail_cnt}), 32'({8'd9, 8'd0}));

        // Drain timeout with no responses.
        drive(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 3; i++) push_op(rand_op());
        drive(0, 1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        idle(DRAIN_TIMEOUT - 1);
        check("tmo_not_yet", 32'({done, err_timeout, busy}), 32'b001);
        idle(1);
        check("tmo_fired", 32'({done, err_timeout, pass}), 32'b110);

        // Start mid-drain clears everything.
        drive(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        bypass_op(rand_op(), 1'b1);
        drive(0, 0, 0, 4'd0, 4'd0, 0, 1, 4'd0, 0);
        for (int i = 0; i < 3; i++) push_op(rand_op());
        drive(0, 1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        idle(10);
        check("mid_drain_dirty", 32'({fail_cnt, err_underflow}), 32'({8'd1, 1'b1}));
        drive(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        check("restart_cleared", 32'({busy, done, pass_cnt, fail_cnt, err_underflow, err_timeout}),
              32'({1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}));
        check("restart_info", 32'(fail_info), 32'd0);

        // Asynchronous reset mid-RUN with pending entries.
        bypass_op(rand_op(), 1'b0);
        bypass_op(rand_op(), 1'b0);
        for (int i = 0; i < 3; i++) push_op(rand_op());
        check("pre_rst_pass_cnt", 32'(pass_cnt), 32'd2);
        rst = 1'b1;
        #1;
        check("async_rst", 32'({pass_cnt, fail_cnt, busy, done, pass, err_underflow, err_overflow, err_timeout}), 32'd0);
        idle(1);
        rst = 1'b0;
        drive(0, 0, 1, 4'd3, 4'd4, 0, 1, 4'd7, 0);
        check("idle_ignores", 32'({pass_cnt, err_underflow, busy}), 32'd0);

        // Counter saturation.
        drive(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 260; i++) bypass_op(rand_op(), 1'b0);
        check("pass_cnt_saturates", 32'(pass_cnt), 32'd255);
        drive(0, 1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
        idle(1);
        check("sat_pass", 32'(pass), 32'd1);

        // Randomized rounds: latency 0..3, occasional corruption and stray results.
        for (int r = 0; r < 4; r++) begin
            drive(1, 0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 0);
            pq.delete();
            for (int c = 0; c < 70; c++) begin
                logic iv, rv, co;
                logic [3:0] s;
                op_t o;
                pend_t p;
                iv = (c < 60) && ($urandom_range(1) == 1);
                o = rand_op();
                if (iv) begin
                    p.o = o;
                    p.rdy = c + r;
                    pq.push_back(p);
                end
                rv = 0; s = 4'd0; co = 0;
                if (pq.size() > 0 && pq[0].rdy <= c) begin
                    p = pq.pop_front();
                    e = ref_calc(p.o.c, int'(p.o.a), int'(p.o.b));
                    if ($urandom_range(7) == 0) e = e ^ 5'h01;
                    rv = 1;
                    {co, s} = e;
                end else if (!iv && $urandom_range(15) == 0) begin
                    rv = 1;
                    s = 4'($urandom_range(15));
                end
                drive(0, (c == 60) ? 1'b1 : 1'b0, iv, o.a, o.b, o.c, rv, s, co);
            end
            check("rand_done", 32'(done), 32'd1);
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
